// File: rtl/adc_acq_sequencer.sv
// Conversion sequencer for the AD4003 ADC array: shared CNVST, SCK burst gate,
// deserializer capture window and sample-ready strobe; continuous or single-shot.
module adc_acq_sequencer #(
  parameter int unsigned ADC_DATA_WIDTH  = 18,
  parameter int unsigned SAMPLE_PERIOD   = 80,
  parameter int unsigned CNV_HIGH_CYCLES = 4,
  parameter int unsigned CONV_CYCLES     = 26,
  parameter int unsigned READ_DELAY      = 4,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 adc_spi_clk,
  input  logic                 rst,
  input  logic                 acq_enable,
  input  logic                 soft_trig,
  input  logic                 ovr_clr,
  output logic                 cnvst,
  output logic                 sck_en,
  output logic                 reader_en_sync,
  output logic                 sample_strobe,
  output logic                 busy,
  output logic                 trig_overrun,
  output logic [CNT_WIDTH-1:0] sample_cnt
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CNV       = 3'd1;
  localparam logic [2:0] CONV_WAIT = 3'd2;
  localparam logic [2:0] SHIFT     = 3'd3;
  localparam logic [2:0] TAIL      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  localparam logic [2:0] HOLDOFF   = 3'd6;

  // Cycle index of DONE relative to the CNVST rise.
  localparam int unsigned BUSY_CYCLES = CONV_CYCLES + READ_DELAY + ADC_DATA_WIDTH;
  localparam int unsigned PER_MAX =
      (SAMPLE_PERIOD > BUSY_CYCLES + 1) ? SAMPLE_PERIOD : BUSY_CYCLES + 1;
  localparam int unsigned PW = $clog2(PER_MAX + 1);

  localparam logic [PW-1:0] CNV_END    = PW'(CNV_HIGH_CYCLES - 1);
  localparam logic [PW-1:0] WAIT_END   = PW'(CONV_CYCLES - 1);
  localparam logic [PW-1:0] SHIFT_END  = PW'(CONV_CYCLES + ADC_DATA_WIDTH - 1);
  localparam logic [PW-1:0] TAIL_END   = PW'(BUSY_CYCLES - 1);
  localparam logic [PW-1:0] PERIOD_END = PW'(SAMPLE_PERIOD - 1);

  logic [2:0]            state_q, state_d;
  logic [PW-1:0]         period_q, period_d;
  logic [READ_DELAY-1:0] rd_dly_q;
  logic                  busy_now;
  logic                  ovr_set;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (acq_enable || soft_trig) state_d = CNV;
      CNV:       if (period_q == CNV_END) state_d = CONV_WAIT;
      CONV_WAIT: if (period_q == WAIT_END) state_d = SHIFT;
      SHIFT:     if (period_q == SHIFT_END) state_d = TAIL;
      TAIL:      if (period_q == TAIL_END) state_d = DONE;
      DONE:      state_d = acq_enable ? HOLDOFF : IDLE;
      HOLDOFF: begin
        // A period shorter than the busy time falls straight through here.
        if (!acq_enable) state_d = IDLE;
        else if (period_q >= PERIOD_END) state_d = CNV;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    period_d = period_q + 1'b1;
    if (state_d == CNV && state_q != CNV) period_d = '0;
    else if (state_q == IDLE) period_d = '0;
  end

  assign busy_now = (state_q != IDLE) && (state_q != HOLDOFF);
  assign ovr_set  = soft_trig && (busy_now || state_q == HOLDOFF);

  assign reader_en_sync = rd_dly_q[READ_DELAY-1];

  always_ff @(posedge adc_spi_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      period_q      <= '0;
      rd_dly_q      <= '0;
      cnvst         <= 1'b0;
      sck_en        <= 1'b0;
      sample_strobe <= 1'b0;
      busy          <= 1'b0;
      trig_overrun  <= 1'b0;
      sample_cnt    <= '0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      rd_dly_q      <= READ_DELAY'({rd_dly_q, sck_en});
      cnvst         <= (state_d == CNV);
      sck_en        <= (state_d == SHIFT);
      sample_strobe <= (state_d == DONE);
      busy          <= (state_d != IDLE) && (state_d != HOLDOFF);
      if (ovr_set) trig_overrun <= 1'b1;
      else if (ovr_clr) trig_overrun <= 1'b0;
      if (state_d == DONE) sample_cnt <= sample_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Scoreboard bench for adc_acq_sequencer: stimulus queues expected CNVST rises and
// strobes, monitors pop and compare them alongside pulse offset/width checks.
module tb_adc_acq_sequencer;

  typedef struct {
    int t;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic acq, trig, clr, acq2;
  logic cnvst, sck_en, reader_en, strobe, busy, ovr;
  logic [31:0] sample_cnt;
  logic cnvst2, sck2, rd2, strobe2, busy2, ovr2;
  logic [3:0] cnt2;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_cnv[$];
  exp_t exp_strb[$];
  int exp2_cnv[$];
  exp_t exp2_strb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_acq_sequencer dut (
    .adc_spi_clk(clk), .rst(rst), .acq_enable(acq), .soft_trig(trig), .ovr_clr(clr),
    .cnvst(cnvst), .sck_en(sck_en), .reader_en_sync(reader_en), .sample_strobe(strobe),
    .busy(busy), .trig_overrun(ovr), .sample_cnt(sample_cnt)
  );

  adc_acq_sequencer #(.SAMPLE_PERIOD(30), .CNT_WIDTH(4)) dut2 (
    .adc_spi_clk(clk), .rst(rst), .acq_enable(acq2), .soft_trig(1'b0), .ovr_clr(1'b0),
    .cnvst(cnvst2), .sck_en(sck2), .reader_en_sync(rd2), .sample_strobe(strobe2),
    .busy(busy2), .trig_overrun(ovr2), .sample_cnt(cnt2)
  );

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // Main DUT monitor: scoreboard pops plus offsets/widths relative to the CNVST rise.
  int cnv_t, sck_t, rd_t;
  logic p_cnv, p_sck, p_rd;
  always @(negedge clk) begin
    if (rst) begin
      p_cnv = 1'b0;
      p_sck = 1'b0;
      p_rd  = 1'b0;
    end else begin
      if (cnvst && !p_cnv) begin
        cnv_t = cyc;
        if (exp_cnv.size() == 0) check("cnvst_unexpected", cyc, -1);
        else check("cnvst_rise", cyc, exp_cnv.pop_front());
      end
      if (!cnvst && p_cnv) check("cnvst_width", cyc - cnv_t, 4);
      if (sck_en && !p_sck) begin
        sck_t = cyc;
        check("sck_offset", cyc - cnv_t, 26);
      end
      if (!sck_en && p_sck) check("sck_width", cyc - sck_t, 18);
      if (reader_en && !p_rd) begin
        rd_t = cyc;
        check("reader_offset", cyc - cnv_t, 30);
      end
      if (!reader_en && p_rd) check("reader_width", cyc - rd_t, 18);
      if (strobe) begin
        if (exp_strb.size() == 0) check("strobe_unexpected", cyc, -1);
        else begin
          exp_t e;
          e = exp_strb.pop_front();
          check("strobe_time", cyc, e.t);
          check("strobe_cnt", int'(sample_cnt), e.cnt);
          check("strobe_busy", int'(busy), 1);
        end
      end
      p_cnv = cnvst;
      p_sck = sck_en;
      p_rd  = reader_en;
    end
  end

  logic p_cnv2;
  always @(negedge clk) begin
    if (rst) p_cnv2 = 1'b0;
    else begin
      if (cnvst2 && !p_cnv2) begin
        if (exp2_cnv.size() == 0) check("d2_cnvst_unexpected", cyc, -1);
        else check("d2_cnvst_rise", cyc, exp2_cnv.pop_front());
      end
      if (strobe2) begin
        if (exp2_strb.size() == 0) check("d2_strobe_unexpected", cyc, -1);
        else begin
          exp_t e;
          e = exp2_strb.pop_front();
          check("d2_strobe_time", cyc, e.t);
          check("d2_cnt", int'(cnt2), e.cnt);
        end
      end
      p_cnv2 = cnvst2;
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int c0;
    int r;
    int n;
    rst = 1'b1; acq = 1'b0; trig = 1'b0; clr = 1'b0; acq2 = 1'b0;
    repeat (3) tick();
    check("reset_outs", int'({cnvst, sck_en, reader_en, strobe, busy, ovr}), 0);
    check("reset_cnt", int'(sample_cnt), 0);
    rst = 1'b0;
    tick();

    // Single shot.
    c0 = cyc + 1;
    exp_cnv.push_back(c0);
    exp_strb.push_back(exp_t'{c0 + 48, 1});
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("single_busy_c1", int'(busy), 1);
    wait_until(c0 + 100);
    check("single_cnt", int'(sample_cnt), 1);
    check("single_idle", int'(busy), 0);
    check("single_no_ovr", int'(ovr), 0);
    n = 1;

    // Continuous for 10 periods, then drop enable at cycle 20 of the last one.
    c0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      exp_cnv.push_back(c0 + 80 * i);
      exp_strb.push_back(exp_t'{c0 + 80 * i + 48, n + i + 1});
    end
    n += 10;
    acq = 1'b1;
    trig = 1'b1;  // simultaneous with enable from IDLE: one conversion, no overrun
    tick();
    trig = 1'b0;
    check("same_cycle_no_ovr", int'(ovr), 0);
    wait_until(c0 + 720 + 20);
    acq = 1'b0;
    wait_until(c0 + 720 + 48 + 200);
    check("cont_cnt", int'(sample_cnt), n);
    check("cont_idle", int'(busy), 0);

    // Overrun during conversion and in HOLDOFF.
    c0 = cyc + 1;
    exp_cnv.push_back(c0);
    exp_cnv.push_back(c0 + 80);
    exp_strb.push_back(exp_t'{c0 + 48, n + 1});
    exp_strb.push_back(exp_t'{c0 + 128, n + 2});
    n += 2;
    acq = 1'b1;
    wait_until(c0 + 10);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    check("ovr_set_busy", int'(ovr), 1);
    wait_until(c0 + 30);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("ovr_clr_lone", int'(ovr), 0);
    wait_until(c0 + 60);
    check("holdoff_not_busy", int'(busy), 0);
    trig = 1'b1;
    clr = 1'b1;
    tick();
    trig = 1'b0;
    clr = 1'b0;
    tick();
    check("ovr_set_beats_clr", int'(ovr), 1);
    wait_until(c0 + 85);
    acq = 1'b0;
    wait_until(c0 + 140);
    check("ovr_sticky", int'(ovr), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("ovr_clr_final", int'(ovr), 0);
    check("ovr_cnt", int'(sample_cnt), n);

    // Reset in the middle of SHIFT.
    c0 = cyc + 1;
    exp_cnv.push_back(c0);
    acq = 1'b1;
    wait_until(c0 + 35);
    check("pre_reset_sck", int'(sck_en), 1);
    rst = 1'b1;
    #1;
    check("rst_outs", int'({cnvst, sck_en, reader_en, strobe, busy, ovr}), 0);
    check("rst_cnt", int'(sample_cnt), 0);
    tick();
    tick();
    r = cyc;
    exp_cnv.push_back(r + 1);
    exp_strb.push_back(exp_t'{r + 49, 1});
    rst = 1'b0;
    wait_until(r + 21);
    acq = 1'b0;
    wait_until(r + 150);
    check("post_rst_cnt", int'(sample_cnt), 1);

    // Short period (stretched to 50) and 4-bit counter wrap on the second DUT.
    c0 = cyc + 1;
    for (int i = 0; i < 17; i++) begin
      exp2_cnv.push_back(c0 + 50 * i);
      exp2_strb.push_back(exp_t'{c0 + 50 * i + 48, (i + 1) % 16});
    end
    acq2 = 1'b1;
    wait_until(c0 + 50 * 16 + 20);
    acq2 = 1'b0;
    wait_until(c0 + 50 * 16 + 200);
    check("d2_final_cnt", int'(cnt2), 1);

    check("cnv_queue_empty", exp_cnv.size(), 0);
    check("strobe_queue_empty", exp_strb.size(), 0);
    check("d2_cnv_queue_empty", exp2_cnv.size(), 0);
    check("d2_strobe_queue_empty", exp2_strb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
